// File: rtl/lcd_pkg.sv
// Shared HD44780 sequencer definitions: timing constants, state encoding, init ROM.
package lcd_pkg;

  localparam int unsigned TIMER_W      = 23;
  localparam int unsigned IDX_W        = 3;
  localparam int unsigned INIT_LEN     = 8;

  localparam int unsigned T_SU_DEFAULT = 13;
  localparam int unsigned T_EN_DEFAULT = 13;

  localparam int unsigned W_42US       = 2100;
  localparam int unsigned W_100US      = 5000;
  localparam int unsigned W_1640US     = 82000;
  localparam int unsigned W_4100US     = 205000;
  localparam int unsigned W_50MS       = 2500000;

  typedef enum logic [2:0] {
    PWR_WAIT = 3'd0,
    LOAD     = 3'd1,
    SETUP    = 3'd2,
    EN_HI    = 3'd3,
    EN_LO    = 3'd4,
    WAIT     = 3'd5,
    IDLE     = 3'd6
  } state_e;

  typedef enum logic [1:0] {
    WS_42US   = 2'd0,
    WS_100US  = 2'd1,
    WS_1640US = 2'd2,
    WS_4100US = 2'd3
  } wait_sel_e;

  // One bus write: register select, data byte and the settle time that follows it.
  typedef struct packed {
    logic      rs;
    logic [7:0] data;
    wait_sel_e wsel;
  } lcd_word_t;

  // Power-on initialisation table (8-bit mode, 2 lines, display on, cursor off).
  function automatic lcd_word_t init_rom(input logic [IDX_W-1:0] idx);
    lcd_word_t w;
    w = '{rs: 1'b0, data: 8'h00, wsel: WS_42US};
    case (idx)
      3'd0: w = '{rs: 1'b0, data: 8'h30, wsel: WS_4100US};
      3'd1: w = '{rs: 1'b0, data: 8'h30, wsel: WS_100US};
      3'd2: w = '{rs: 1'b0, data: 8'h30, wsel: WS_100US};
      3'd3: w = '{rs: 1'b0, data: 8'h38, wsel: WS_42US};
      3'd4: w = '{rs: 1'b0, data: 8'h08, wsel: WS_42US};
      3'd5: w = '{rs: 1'b0, data: 8'h01, wsel: WS_1640US};
      3'd6: w = '{rs: 1'b0, data: 8'h06, wsel: WS_42US};
      3'd7: w = '{rs: 1'b0, data: 8'h0C, wsel: WS_42US};
      default: w = '{rs: 1'b0, data: 8'h00, wsel: WS_42US};
    endcase
    return w;
  endfunction

  // Clear display and return home are the only slow instructions.
  function automatic wait_sel_e host_wait_sel(input logic rs, input logic [7:0] data);
    if (!rs && (data == 8'h01 || data == 8'h02)) return WS_1640US;
    return WS_42US;
  endfunction

endpackage

// File: rtl/lcd_wait_timer.sv
// Clear/count/compare timer; saturates at the limit so it never wraps.
module lcd_wait_timer
  import lcd_pkg::*;
(
  input  logic               CLK,
  input  logic               RST_N,
  input  logic               clr,
  input  logic [TIMER_W-1:0] limit,
  output logic               done
);

  logic [TIMER_W-1:0] count_q, count_d;

  assign done = (count_q == limit);

  // Next count: restart on clear, hold at limit, otherwise increment.
  always_comb begin
    count_d = count_q;
    if (clr)       count_d = '0;
    else if (!done) count_d = count_q + TIMER_W'(1);
  end

  // Counter register with synchronous reset.
  always_ff @(posedge CLK) begin
    if (!RST_N) count_q <= '0;
    else        count_q <= count_d;
  end

endmodule

// File: rtl/lcd_cmd_seq.sv
// HD44780 8-bit write sequencer: power-on init, then single host byte writes.
module lcd_cmd_seq
  import lcd_pkg::*;
#(
  parameter int unsigned T_SU       = T_SU_DEFAULT,
  parameter int unsigned T_EN       = T_EN_DEFAULT,
  parameter int unsigned WAIT_42US   = W_42US,
  parameter int unsigned WAIT_100US  = W_100US,
  parameter int unsigned WAIT_1640US = W_1640US,
  parameter int unsigned WAIT_4100US = W_4100US,
  parameter int unsigned WAIT_50MS   = W_50MS
) (
  input  logic       CLK,
  input  logic       RST_N,
  input  logic       cmd_valid,
  input  logic       cmd_rs,
  input  logic [7:0] cmd_data,
  output logic       cmd_ready,
  output logic       init_done,
  output logic       LCD_RS,
  output logic       LCD_RW,
  output logic       LCD_EN,
  output logic [7:0] LCD_DATA
);

  state_e             state_q;
  logic [IDX_W-1:0]   idx_q;
  wait_sel_e          wsel_q;
  logic               cmd_ready_q, init_done_q, lcd_en_q, lcd_rs_q;
  logic [7:0]         lcd_data_q;

  logic [TIMER_W-1:0] limit_c;
  logic               clr_c, done_c;
  logic [IDX_W-1:0]   idx_next_c;
  lcd_word_t          rom_next_c;

  function automatic logic [TIMER_W-1:0] wait_limit(input wait_sel_e w);
    logic [TIMER_W-1:0] l;
    l = TIMER_W'(WAIT_42US - 1);
    case (w)
      WS_42US:   l = TIMER_W'(WAIT_42US - 1);
      WS_100US:  l = TIMER_W'(WAIT_100US - 1);
      WS_1640US: l = TIMER_W'(WAIT_1640US - 1);
      WS_4100US: l = TIMER_W'(WAIT_4100US - 1);
      default:   l = TIMER_W'(WAIT_42US - 1);
    endcase
    return l;
  endfunction

  // Terminal count for the current state (duration - 1).
  always_comb begin
    limit_c = '0;
    case (state_q)
      PWR_WAIT:     limit_c = TIMER_W'(WAIT_50MS - 1);
      SETUP, EN_LO: limit_c = TIMER_W'(T_SU - 1);
      EN_HI:        limit_c = TIMER_W'(T_EN - 1);
      WAIT:         limit_c = wait_limit(wsel_q);
      default:      limit_c = '0;
    endcase
  end

  // Next init ROM entry: index 0 leaving power-up wait, index+1 after a settle wait.
  always_comb begin
    idx_next_c = '0;
    if (state_q == WAIT) idx_next_c = idx_q + IDX_W'(1);
    rom_next_c = init_rom(idx_next_c);
  end

  // Timer restarts whenever a state is left; LOAD and IDLE never use it.
  assign clr_c = done_c || (state_q == LOAD) || (state_q == IDLE);

  lcd_wait_timer u_timer (
    .CLK   (CLK),
    .RST_N (RST_N),
    .clr   (clr_c),
    .limit (limit_c),
    .done  (done_c)
  );

  // Sequencer FSM with registered bus and handshake outputs.
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state_q     <= PWR_WAIT;
      idx_q       <= '0;
      wsel_q      <= WS_42US;
      cmd_ready_q <= 1'b0;
      init_done_q <= 1'b0;
      lcd_en_q    <= 1'b0;
      lcd_rs_q    <= 1'b0;
      lcd_data_q  <= 8'h00;
    end else begin
      case (state_q)
        PWR_WAIT: begin
          if (done_c) begin
            state_q    <= LOAD;
            idx_q      <= idx_next_c;
            lcd_rs_q   <= rom_next_c.rs;
            lcd_data_q <= rom_next_c.data;
            wsel_q     <= rom_next_c.wsel;
          end
        end
        LOAD: state_q <= SETUP;
        SETUP: begin
          if (done_c) begin
            state_q  <= EN_HI;
            lcd_en_q <= 1'b1;
          end
        end
        EN_HI: begin
          if (done_c) begin
            state_q  <= EN_LO;
            lcd_en_q <= 1'b0;
          end
        end
        EN_LO: begin
          if (done_c) state_q <= WAIT;
        end
        WAIT: begin
          if (done_c) begin
            if (!init_done_q && idx_q != IDX_W'(INIT_LEN - 1)) begin
              state_q    <= LOAD;
              idx_q      <= idx_next_c;
              lcd_rs_q   <= rom_next_c.rs;
              lcd_data_q <= rom_next_c.data;
              wsel_q     <= rom_next_c.wsel;
            end else begin
              state_q     <= IDLE;
              cmd_ready_q <= 1'b1;
              init_done_q <= 1'b1;
            end
          end
        end
        IDLE: begin
          if (cmd_valid && cmd_ready_q) begin
            state_q     <= LOAD;
            cmd_ready_q <= 1'b0;
            lcd_rs_q    <= cmd_rs;
            lcd_data_q  <= cmd_data;
            wsel_q      <= host_wait_sel(cmd_rs, cmd_data);
          end
        end
        default: state_q <= PWR_WAIT;
      endcase
    end
  end

  assign cmd_ready = cmd_ready_q;
  assign init_done = init_done_q;
  assign LCD_RS    = lcd_rs_q;
  assign LCD_RW    = 1'b0;
  assign LCD_EN    = lcd_en_q;
  assign LCD_DATA  = lcd_data_q;

endmodule

// File: tb/tb_lcd_cmd_seq.sv
// Directed bench for lcd_cmd_seq with shortened settle waits.
module tb_lcd_cmd_seq;

  localparam int unsigned TSU   = 13;
  localparam int unsigned TEN   = 13;
  localparam int unsigned W42   = 20;
  localparam int unsigned W100  = 30;
  localparam int unsigned W1640 = 60;
  localparam int unsigned W4100 = 90;
  localparam int unsigned W50   = 300;

  logic       CLK = 1'b0;
  logic       RST_N;
  logic       cmd_valid;
  logic       cmd_rs;
  logic [7:0] cmd_data;
  logic       cmd_ready;
  logic       init_done;
  logic       LCD_RS;
  logic       LCD_RW;
  logic       LCD_EN;
  logic [7:0] LCD_DATA;

  int n_checks = 0;
  int n_errors = 0;

  logic [7:0] rom_data [8] = '{8'h30, 8'h30, 8'h30, 8'h38, 8'h08, 8'h01, 8'h06, 8'h0C};
  int         rom_wait [8] = '{W4100, W100, W100, W42, W42, W1640, W42, W42};

  lcd_cmd_seq #(
    .T_SU        (TSU),
    .T_EN        (TEN),
    .WAIT_42US   (W42),
    .WAIT_100US  (W100),
    .WAIT_1640US (W1640),
    .WAIT_4100US (W4100),
    .WAIT_50MS   (W50)
  ) dut (
    .CLK       (CLK),
    .RST_N     (RST_N),
    .cmd_valid (cmd_valid),
    .cmd_rs    (cmd_rs),
    .cmd_data  (cmd_data),
    .cmd_ready (cmd_ready),
    .init_done (init_done),
    .LCD_RS    (LCD_RS),
    .LCD_RW    (LCD_RW),
    .LCD_EN    (LCD_EN),
    .LCD_DATA  (LCD_DATA)
  );

  always #5 CLK = ~CLK;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Observe one EN pulse: EN-low samples before it, bus value, high width, stability around it.
  task automatic capture_pulse(output int gap, output logic [8:0] bus, output int hi,
                               output int pre, output int post, output bit glitch,
                               output bit timeout);
    logic [8:0] prev, cur;
    int stable;
    gap = 0; hi = 0; pre = 0; post = 0; glitch = 0; timeout = 0; stable = 0;
    bus = '0;
    prev = {LCD_RS, LCD_DATA};
    @(negedge CLK);
    while (LCD_EN !== 1'b1) begin
      cur = {LCD_RS, LCD_DATA};
      if (cur == prev) stable++;
      else             stable = 1;
      prev = cur;
      gap++;
      if (gap > 1000) begin
        timeout = 1;
        return;
      end
      @(negedge CLK);
    end
    bus = {LCD_RS, LCD_DATA};
    pre = (bus == prev) ? stable : 0;
    while (LCD_EN === 1'b1 && hi < 1000) begin
      if ({LCD_RS, LCD_DATA} != bus) glitch = 1;
      hi++;
      @(negedge CLK);
    end
    while (post < int'(TSU) && LCD_EN === 1'b0 && {LCD_RS, LCD_DATA} == bus) begin
      post++;
      if (post < int'(TSU)) @(negedge CLK);
    end
  endtask

  task automatic check_pulse(input string tag, input int exp_gap, input logic rs,
                             input logic [7:0] d);
    int gap, hi, pre, post;
    logic [8:0] bus;
    bit glitch, timeout;
    capture_pulse(gap, bus, hi, pre, post, glitch, timeout);
    check_eq({tag, "_no_timeout"}, 32'(timeout), 32'd0);
    if (timeout) return;
    check_eq({tag, "_gap"}, 32'(gap), 32'(exp_gap));
    check_eq({tag, "_rs"}, 32'(bus[8]), 32'(rs));
    check_eq({tag, "_data"}, 32'(bus[7:0]), 32'(d));
    check_eq({tag, "_en_width"}, 32'(hi), 32'(TEN));
    check_eq({tag, "_setup_ok"}, 32'(pre >= int'(TSU)), 32'd1);
    check_eq({tag, "_hold"}, 32'(post), 32'(TSU));
    check_eq({tag, "_stable_hi"}, 32'(glitch), 32'd0);
  endtask

  task automatic wait_ready(output int n);
    n = 0;
    do begin
      @(negedge CLK);
      n++;
    end while (cmd_ready !== 1'b1 && n < 5000);
  endtask

  // Release reset at a falling edge and follow the whole power-on sequence.
  task automatic do_init();
    int n;
    @(negedge CLK);
    RST_N = 1'b1;
    for (int k = 0; k < 8; k++) begin
      check_pulse($sformatf("init%0d", k), (k == 0) ? int'(W50 + 13) : rom_wait[k-1] + 14,
                  1'b0, rom_data[k]);
      if (k == 0) check_eq("init_done_low", 32'(init_done), 32'd0);
    end
    wait_ready(n);
    check_eq("init_done_delay", 32'(n), 32'(W42 + 1));
    check_eq("init_done_high", 32'(init_done), 32'd1);
    check_eq("lcd_rw_zero", 32'(LCD_RW), 32'd0);
  endtask

  // Host write issued from an IDLE falling edge; inputs are scrambled after acceptance.
  task automatic host_cmd(input string tag, input logic rs, input logic [7:0] d, input int wt);
    int n;
    cmd_valid = 1'b1; cmd_rs = rs; cmd_data = d;
    @(negedge CLK);
    check_eq({tag, "_ready_fall"}, 32'(cmd_ready), 32'd0);
    check_eq({tag, "_load_data"}, 32'(LCD_DATA), 32'(d));
    cmd_valid = 1'b0; cmd_rs = ~rs; cmd_data = ~d;
    check_pulse(tag, int'(TSU), rs, d);
    wait_ready(n);
    check_eq({tag, "_ready_delay"}, 32'(n), 32'(wt + 1));
  endtask

  initial begin
    int n;
    RST_N = 1'b0; cmd_valid = 1'b0; cmd_rs = 1'b0; cmd_data = 8'h00;
    repeat (3) @(negedge CLK);
    check_eq("rst_cmd_ready", 32'(cmd_ready), 32'd0);
    check_eq("rst_init_done", 32'(init_done), 32'd0);
    check_eq("rst_lcd_en", 32'(LCD_EN), 32'd0);
    check_eq("rst_lcd_rs", 32'(LCD_RS), 32'd0);
    check_eq("rst_lcd_data", 32'(LCD_DATA), 32'h00);
    check_eq("rst_lcd_rw", 32'(LCD_RW), 32'd0);

    do_init();

    host_cmd("wr_41", 1'b1, 8'h41, W42);
    host_cmd("clear", 1'b0, 8'h01, W1640);
    host_cmd("ddram80", 1'b0, 8'h80, W42);
    host_cmd("home", 1'b0, 8'h02, W1640);
    host_cmd("char01", 1'b1, 8'h01, W42);
    host_cmd("instr03", 1'b0, 8'h03, W42);

    // Back-to-back: valid held high, second command taken on the first IDLE cycle.
    cmd_valid = 1'b1; cmd_rs = 1'b0; cmd_data = 8'h80;
    @(negedge CLK);
    check_eq("b2b_a_load", 32'(LCD_DATA), 32'h80);
    cmd_rs = 1'b1; cmd_data = 8'h0F;
    check_pulse("b2b_a", int'(TSU), 1'b0, 8'h80);
    wait_ready(n);
    check_eq("b2b_a_ready_delay", 32'(n), 32'(W42 + 1));
    @(negedge CLK);
    check_eq("b2b_b_ready_fall", 32'(cmd_ready), 32'd0);
    check_eq("b2b_b_load", 32'({LCD_RS, LCD_DATA}), 32'h10F);
    cmd_valid = 1'b0;
    check_pulse("b2b_b", int'(TSU), 1'b1, 8'h0F);
    wait_ready(n);
    check_eq("b2b_b_ready_delay", 32'(n), 32'(W42 + 1));

    // Reset in the middle of an EN pulse.
    cmd_valid = 1'b1; cmd_rs = 1'b1; cmd_data = 8'h41;
    @(negedge CLK);
    cmd_valid = 1'b0;
    n = 0;
    while (LCD_EN !== 1'b1 && n < 200) begin
      @(negedge CLK);
      n++;
    end
    check_eq("midop_en_seen", 32'(LCD_EN), 32'd1);
    repeat (5) @(negedge CLK);
    RST_N = 1'b0;
    @(negedge CLK);
    check_eq("midop_en_drop", 32'(LCD_EN), 32'd0);
    check_eq("midop_init_done", 32'(init_done), 32'd0);
    check_eq("midop_ready", 32'(cmd_ready), 32'd0);
    check_eq("midop_data", 32'(LCD_DATA), 32'h00);

    // Early request held through the whole re-init.
    cmd_valid = 1'b1; cmd_rs = 1'b1; cmd_data = 8'h55;
    repeat (2) @(negedge CLK);
    do_init();
    @(negedge CLK);
    check_eq("early_ready_fall", 32'(cmd_ready), 32'd0);
    check_eq("early_load", 32'({LCD_RS, LCD_DATA}), 32'h155);
    cmd_valid = 1'b0;
    check_pulse("early", int'(TSU), 1'b1, 8'h55);
    wait_ready(n);
    check_eq("early_ready_delay", 32'(n), 32'(W42 + 1));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
